// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the writeback path: the buffered entry record,
// the load funct3 encodings, and the writeback buffer occupancy states.
package pipeline_pkg;

    localparam int WB_XLEN    = 64;
    localparam int WB_RADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [WB_XLEN-1:0]    pc;
        logic [WB_XLEN-1:0]    data;
        logic [WB_RADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  misaligned;
    } mem_wb_entry_t;

    typedef enum logic [1:0] {WB_EMPTY, WB_ONE, WB_TWO} wb_state_t;

endpackage

// File: rtl/load_align.sv
// Combinational load extractor: selects the addressed bytes out of an aligned
// doubleword, sign/zero-extends them and flags misaligned accesses.
module load_align
    import pipeline_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [XLEN-1:0]    shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;
    logic signed [31:0] word_s;

    always_comb begin
        shifted    = raw >> {off, 3'b000};
        byte_s     = shifted[7:0];
        half_s     = shifted[15:0];
        word_s     = shifted[31:0];
        data       = shifted;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:  begin
                data       = {{(XLEN-16){half_s[15]}}, half_s};
                misaligned = off[0];
            end
            F3_LW:  begin
                data       = {{(XLEN-32){word_s[31]}}, word_s};
                misaligned = |off[1:0];
            end
            F3_LBU: data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, shifted[15:0]};
                misaligned = off[0];
            end
            F3_LWU: begin
                data       = {{(XLEN-32){1'b0}}, shifted[31:0]};
                misaligned = |off[1:0];
            end
            // LD and the unused 111 encoding both take the full doubleword
            default: misaligned = |off;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: 2-entry skid buffer of memory-stage results, register file
// write port and instret counter. Define WB_BYPASS_EN to add the fwd_* outputs.
module mem_wb_stage
    import pipeline_pkg::*;
#(
    parameter int XLEN    = WB_XLEN,
    parameter int RADDR_W = WB_RADDR_W,
    parameter int CNT_W   = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_valid,
    output logic               mem_ready,
    input  logic [XLEN-1:0]    mem_pc,
    input  logic [XLEN-1:0]    mem_alu_data,
    input  logic [XLEN-1:0]    mem_load_raw,
    input  logic               mem_is_load,
    input  logic [2:0]         mem_funct3,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_reg_write,
    input  logic               wb_hold,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               retire_valid,
    output logic [XLEN-1:0]    retire_pc,
    output logic               load_misalign,
    output logic [CNT_W-1:0]   instret
`ifdef WB_BYPASS_EN
    ,
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [XLEN-1:0]    fwd_data
`endif
);

    wb_state_t     state;
    mem_wb_entry_t head;
    mem_wb_entry_t skid;
    mem_wb_entry_t new_entry;

    logic [XLEN-1:0] load_data;
    logic            load_mis;
    logic            accept;
    logic            head_valid;
    logic            retire;

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw        (mem_load_raw),
        .off        (mem_alu_data[2:0]),
        .funct3     (mem_funct3),
        .data       (load_data),
        .misaligned (load_mis)
    );

    always_comb begin
        new_entry            = '0;
        new_entry.pc         = mem_pc;
        new_entry.data       = mem_is_load ? load_data : mem_alu_data;
        new_entry.rd         = mem_rd;
        new_entry.reg_write  = mem_reg_write;
        new_entry.misaligned = mem_is_load & load_mis;
    end

    assign accept     = mem_valid && mem_ready;
    assign head_valid = (state != WB_EMPTY);
    // Reset suppresses retirement so a discarded entry never reaches the register file
    assign retire     = head_valid && !wb_hold && !reset;

    assign retire_valid  = retire;
    assign retire_pc     = head.pc;
    assign rf_waddr      = head.rd;
    assign rf_wdata      = head.data;
    assign load_misalign = retire && head.misaligned;
    assign rf_we         = retire && head.reg_write && (head.rd != '0) && !head.misaligned;

`ifdef WB_BYPASS_EN
    assign fwd_valid = head_valid && head.reg_write && (head.rd != '0) && !head.misaligned;
    assign fwd_rd    = head.rd;
    assign fwd_data  = head.data;
`endif

    // p0: buffer occupancy FSM, entry storage and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WB_EMPTY;
            head      <= '0;
            skid      <= '0;
            mem_ready <= 1'b1;
            instret   <= '0;
        end else begin
            if (retire)
                instret <= instret + CNT_W'(1);
            case (state)
                WB_EMPTY: begin
                    if (accept) begin
                        head  <= new_entry;
                        state <= WB_ONE;
                    end
                    mem_ready <= 1'b1;
                end
                WB_ONE: begin
                    if (accept && !retire) begin
                        skid      <= new_entry;
                        state     <= WB_TWO;
                        mem_ready <= 1'b0;
                    end else if (accept && retire) begin
                        head      <= new_entry;
                        mem_ready <= 1'b1;
                    end else if (retire) begin
                        state     <= WB_EMPTY;
                        mem_ready <= 1'b1;
                    end else begin
                        mem_ready <= 1'b1;
                    end
                end
                WB_TWO: begin
                    if (retire) begin
                        head      <= skid;
                        state     <= WB_ONE;
                        mem_ready <= 1'b1;
                    end else begin
                        mem_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= WB_EMPTY;
                    mem_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (instret narrowed to 8 bits).
module tb_mem_wb_stage;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;
    localparam int CNT_W   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               mem_valid;
    logic               mem_ready;
    logic [XLEN-1:0]    mem_pc;
    logic [XLEN-1:0]    mem_alu_data;
    logic [XLEN-1:0]    mem_load_raw;
    logic               mem_is_load;
    logic [2:0]         mem_funct3;
    logic [RADDR_W-1:0] mem_rd;
    logic               mem_reg_write;
    logic               wb_hold;
    logic               rf_we;
    logic [RADDR_W-1:0] rf_waddr;
    logic [XLEN-1:0]    rf_wdata;
    logic               retire_valid;
    logic [XLEN-1:0]    retire_pc;
    logic               load_misalign;
    logic [CNT_W-1:0]   instret;

    int checks   = 0;
    int failures = 0;
    logic [CNT_W-1:0] exp_instret = '0;

    mem_wb_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_pc        (mem_pc),
        .mem_alu_data  (mem_alu_data),
        .mem_load_raw  (mem_load_raw),
        .mem_is_load   (mem_is_load),
        .mem_funct3    (mem_funct3),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_hold       (wb_hold),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .retire_valid  (retire_valid),
        .retire_pc     (retire_pc),
        .load_misalign (load_misalign),
        .instret       (instret)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] alu,
                        input logic [XLEN-1:0] raw, input logic is_load,
                        input logic [2:0] f3, input logic [RADDR_W-1:0] rd,
                        input logic rw);
        mem_valid     = 1'b1;
        mem_pc        = pc;
        mem_alu_data  = alu;
        mem_load_raw  = raw;
        mem_is_load   = is_load;
        mem_funct3    = f3;
        mem_rd        = rd;
        mem_reg_write = rw;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_hold = 1'b0; idle();
        mem_pc = '0; mem_alu_data = '0; mem_load_raw = '0; mem_is_load = 1'b0;
        mem_funct3 = '0; mem_rd = '0; mem_reg_write = 1'b0;
        step(); step();
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL reset_ready actual=%b expected=1", mem_ready); end
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we actual=%b expected=0", rf_we); end
        checks++; if (retire_valid !== 1'b0) begin failures++; $display("FAIL reset_retire actual=%b expected=0", retire_valid); end
        checks++; if (load_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign actual=%b expected=0", load_misalign); end
        checks++; if (instret !== 8'd0) begin failures++; $display("FAIL reset_instret actual=%0d expected=0", instret); end
        checks++; if ({rf_waddr, rf_wdata, retire_pc} !== '0) begin failures++; $display("FAIL reset_data actual=%h/%h/%h expected=0", rf_waddr, rf_wdata, retire_pc); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_lb();
        send(64'h100, 64'h2003, 64'h0000_0000_8000_0000, 1'b1, 3'b000, 5'd5, 1'b1);
        step();
        checks++; if (rf_wdata !== 64'hFFFF_FFFF_FFFF_FF80) begin failures++; $display("FAIL lb_neg actual=%h expected=ffffffffffffff80", rf_wdata); end
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5) begin failures++; $display("FAIL lb_we actual=%b/%0d expected=1/5", rf_we, rf_waddr); end
        send(64'h104, 64'h2003, 64'h0000_0000_7F00_0000, 1'b1, 3'b000, 5'd6, 1'b1);
        step();
        checks++; if (rf_wdata !== 64'h0000_0000_0000_007F) begin failures++; $display("FAIL lb_pos actual=%h expected=7f", rf_wdata); end
        send(64'h108, 64'h2003, 64'h0000_0000_00FF_FFFF, 1'b1, 3'b000, 5'd7, 1'b1);
        step();
        checks++; if (rf_wdata !== 64'h0 || retire_pc !== 64'h108) begin failures++; $display("FAIL lb_zero actual=%h pc=%h expected=0 pc=108", rf_wdata, retire_pc); end
        idle();
        step();
        exp_instret += 8'd3;
        checks++; if (retire_valid !== 1'b0 || rf_we !== 1'b0) begin failures++; $display("FAIL lb_drain actual=%b/%b expected=0/0", retire_valid, rf_we); end
        checks++; if (instret !== exp_instret) begin failures++; $display("FAIL lb_instret actual=%0d expected=%0d", instret, exp_instret); end
    endtask

    task automatic test_lwu();
        send(64'h200, 64'h1000_0004, 64'hDEAD_BEEF_0000_0000, 1'b1, 3'b110, 5'd9, 1'b1);
        #1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lwu_pre_we actual=%b expected=0", rf_we); end
        step();
        idle();
        checks++; if (rf_we !== 1'b1 || rf_wdata !== 64'h0000_0000_DEAD_BEEF) begin failures++; $display("FAIL lwu_data actual=%b/%h expected=1/00000000deadbeef", rf_we, rf_wdata); end
        step();
        exp_instret += 8'd1;
        checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL lwu_one_cycle actual=%b expected=0", rf_we); end
    endtask

    task automatic test_misalign();
        send(64'h300, 64'h4004, 64'h1122_3344_5566_7788, 1'b1, 3'b011, 5'd10, 1'b1);
        step();
        idle();
        checks++; if (load_misalign !== 1'b1 || rf_we !== 1'b0 || retire_valid !== 1'b1) begin failures++; $display("FAIL ld_misalign actual=mis%b we%b rv%b expected=mis1 we0 rv1", load_misalign, rf_we, retire_valid); end
        checks++; if (retire_pc !== 64'h300) begin failures++; $display("FAIL ld_misalign_pc actual=%h expected=300", retire_pc); end
        step();
        exp_instret += 8'd1;
        checks++; if (instret !== exp_instret || load_misalign !== 1'b0) begin failures++; $display("FAIL ld_misalign_cnt actual=%0d/%b expected=%0d/0", instret, load_misalign, exp_instret); end
    endtask

    task automatic test_hold();
        wb_hold = 1'b1;
        send(64'hA0, 64'hAAA, '0, 1'b0, 3'b000, 5'd1, 1'b1);
        step();
        send(64'hB0, 64'hBBB, '0, 1'b0, 3'b000, 5'd2, 1'b1);
        step();
        checks++; if (mem_ready !== 1'b0 || retire_valid !== 1'b0) begin failures++; $display("FAIL hold_full actual=rdy%b rv%b expected=rdy0 rv0", mem_ready, retire_valid); end
        send(64'hC0, 64'hCCC, '0, 1'b0, 3'b000, 5'd3, 1'b1);
        step();
        checks++; if (mem_ready !== 1'b0 || rf_wdata !== 64'hAAA) begin failures++; $display("FAIL hold_stall actual=rdy%b %h expected=rdy0 aaa", mem_ready, rf_wdata); end
        wb_hold = 1'b0;
        #1;
        checks++; if (retire_valid !== 1'b1 || rf_wdata !== 64'hAAA || rf_waddr !== 5'd1) begin failures++; $display("FAIL hold_A actual=%b/%h expected=1/aaa", retire_valid, rf_wdata); end
        step();
        checks++; if (rf_wdata !== 64'hBBB || mem_ready !== 1'b1) begin failures++; $display("FAIL hold_B actual=%h rdy%b expected=bbb rdy1", rf_wdata, mem_ready); end
        step();
        idle();
        checks++; if (rf_wdata !== 64'hCCC || retire_pc !== 64'hC0) begin failures++; $display("FAIL hold_C actual=%h/%h expected=ccc/c0", rf_wdata, retire_pc); end
        step();
        exp_instret += 8'd3;
        checks++; if (retire_valid !== 1'b0 || instret !== exp_instret) begin failures++; $display("FAIL hold_drain actual=%b/%0d expected=0/%0d", retire_valid, instret, exp_instret); end
    endtask

    task automatic test_rd0_wrap();
        int k;
        send(64'h400, 64'h55, '0, 1'b0, 3'b000, 5'd0, 1'b1);
        step();
        idle();
        checks++; if (rf_we !== 1'b0 || retire_valid !== 1'b1) begin failures++; $display("FAIL rd0 actual=we%b rv%b expected=we0 rv1", rf_we, retire_valid); end
        step();
        exp_instret += 8'd1;
        k = 255 - int'(exp_instret);
        send(64'h500, 64'h66, '0, 1'b0, 3'b000, 5'd3, 1'b1);
        repeat (k) step();
        idle();
        step();
        checks++; if (instret !== 8'hFF) begin failures++; $display("FAIL instret_max actual=%0d expected=255", instret); end
        send(64'h600, 64'h77, '0, 1'b0, 3'b000, 5'd3, 1'b1);
        step();
        idle();
        step();
        exp_instret = 8'd0;
        checks++; if (instret !== 8'd0) begin failures++; $display("FAIL instret_wrap actual=%0d expected=0", instret); end
    endtask

    task automatic test_reset_mid();
        wb_hold = 1'b1;
        send(64'h700, 64'h123, '0, 1'b0, 3'b000, 5'd4, 1'b1);
        step();
        send(64'h704, 64'h456, '0, 1'b0, 3'b000, 5'd5, 1'b1);
        step();
        idle();
        checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL mid_full actual=%b expected=0", mem_ready); end
        reset = 1'b1;
        wb_hold = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || retire_valid !== 1'b0) begin failures++; $display("FAIL mid_no_partial actual=%b/%b expected=0/0", rf_we, retire_valid); end
        step();
        checks++; if (mem_ready !== 1'b1 || rf_we !== 1'b0 || instret !== 8'd0) begin failures++; $display("FAIL mid_reset actual=rdy%b we%b cnt%0d expected=rdy1 we0 cnt0", mem_ready, rf_we, instret); end
        reset = 1'b0;
        step();
        checks++; if (retire_valid !== 1'b0 || rf_wdata !== 64'h0 || instret !== 8'd0) begin failures++; $display("FAIL mid_after actual=%b/%h/%0d expected=0/0/0", retire_valid, rf_wdata, instret); end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_lwu();
        test_misalign();
        test_hold();
        test_rd0_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
